// File: rtl/pwm_actuator.sv
// Complementary PWM generator with dead time and a once-per-period sample strobe.
// Duty is captured from the signed fixed-point controller output at each period boundary.
module pwm_actuator #(
    parameter int size   = 19,
    parameter int FRAC   = 8,
    parameter int PERIOD = 500,
    parameter int DT     = 4,
    parameter int CW     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic signed [size-1:0] pidk,
    output logic                   EN,
    output logic                   pwm_h,
    output logic                   pwm_l,
    output logic                   sat_hi,
    output logic                   sat_lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CW-1:0]          LAST_CNT = CW'(PERIOD - 1);
    localparam logic [CW-1:0]          DT_CNT   = CW'(DT);
    localparam logic [CW-1:0]          L_END    = CW'(PERIOD - DT);
    localparam logic [CW:0]            DT_WIDE  = (CW + 1)'(DT);
    localparam logic signed [size-1:0] PERIOD_S = size'(PERIOD);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] duty_q, duty_d;
    logic          sat_hi_q, sat_hi_d;
    logic          sat_lo_q, sat_lo_d;
    logic          en_q, en_d;
    logic          pwm_h_q, pwm_h_d;
    logic          pwm_l_q, pwm_l_d;

    logic signed [size-1:0] duty_raw;
    logic [CW-1:0]          cap_duty;
    logic                   cap_hi;
    logic                   cap_lo;
    logic                   load;
    logic                   running;
    logic [CW:0]            l_start;

    // Arithmetic shift keeps the sign so negative commands clamp to zero duty.
    assign duty_raw = pidk >>> FRAC;

    always_comb begin
        cap_duty = '0;
        cap_hi   = 1'b0;
        cap_lo   = 1'b0;
        if (duty_raw < 0) begin
            cap_lo = 1'b1;
        end else if (duty_raw > PERIOD_S) begin
            cap_duty = CW'(PERIOD);
            cap_hi   = 1'b1;
        end else begin
            cap_duty = duty_raw[CW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (go) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    load  = 1'b1;
                    if (!go) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Duty and flags only change on a period boundary, so a period is never cut short.
    always_comb begin
        duty_d   = duty_q;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;
        if (load) begin
            duty_d   = cap_duty;
            sat_hi_d = cap_hi;
            sat_lo_d = cap_lo;
        end
    end

    assign running = (state_q == RUN);
    assign l_start = {1'b0, duty_q} + DT_WIDE;

    // High and low windows are disjoint by construction: cnt < duty versus cnt >= duty+DT.
    always_comb begin
        en_d    = running && (cnt_q == '0);
        pwm_h_d = running && (cnt_q >= DT_CNT) && (cnt_q < duty_q);
        pwm_l_d = running && ({1'b0, cnt_q} >= l_start) && (cnt_q < L_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            duty_q   <= '0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            en_q     <= 1'b0;
            pwm_h_q  <= 1'b0;
            pwm_l_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
            en_q     <= en_d;
            pwm_h_q  <= pwm_h_d;
            pwm_l_q  <= pwm_l_d;
        end
    end

    assign EN     = en_q;
    assign pwm_h  = pwm_h_q;
    assign pwm_l  = pwm_l_q;
    assign sat_hi = sat_hi_q;
    assign sat_lo = sat_lo_q;

endmodule

// File: tb/tb_pwm_actuator.sv
// Bench for pwm_actuator: per-period gate counts scored against a table of commands,
// plus hand sequences for idle glitches, go drop and mid-period reset.
module tb_pwm_actuator;

    localparam int NV = 13;
    localparam int DT = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               go;
    logic signed [18:0] pidk;
    logic               EN, pwm_h, pwm_l, sat_hi, sat_lo;

    pwm_actuator dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .pidk   (pidk),
        .EN     (EN),
        .pwm_h  (pwm_h),
        .pwm_l  (pwm_l),
        .sat_hi (sat_hi),
        .sat_lo (sat_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pidk;
        int h;
        int l;
        int shi;
        int slo;
    } vec_t;

    vec_t tbl [NV];
    vec_t sb_q [$];

    int checks = 0;
    int errors = 0;
    int en_seen = 0;
    int en_total = 0;
    int period_no = 0;
    bit mon_en = 1'b0;
    bit flush_req = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (EN) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL en_timeout: got no EN within 1200 cycles expected a pulse at %0t", $time);
    endtask

    // Always-on checker: gate overlap, dead time on every rising edge, EN tally.
    initial begin
        int  low_len = 0;
        int  last_gate = 0;
        bit  ph = 1'b0;
        bit  pl = 1'b0;
        forever begin
            @(negedge clk);
            chk("no_overlap", int'(pwm_h & pwm_l), 0);
            if (EN) en_seen++;
            if (((pwm_h && !ph) || (pwm_l && !pl)) && last_gate != 0)
                chk("dead_time_ok", int'(low_len >= DT), 1);
            if (pwm_h || pwm_l) begin
                low_len   = 0;
                last_gate = pwm_h ? 1 : 2;
            end else begin
                low_len++;
            end
            ph = pwm_h;
            pl = pwm_l;
        end
    end

    // Period monitor: a period in gate time runs from one EN cycle to the cycle before the next.
    initial begin
        int  h_c = 0, l_c = 0, h_r = 0, l_r = 0;
        int  o_hi = 0, o_lo = 0;
        bit  in_period = 1'b0;
        bit  ph = 1'b0, pl = 1'b0;
        vec_t e;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                in_period = 1'b0;
            end else begin
                if (EN || flush_req) begin
                    if (in_period) begin
                        if (sb_q.size() == 0) begin
                            chk("sb_underflow", 1, 0);
                        end else begin
                            e = sb_q.pop_front();
                            $display("period %0d pidk=%0d h=%0d/%0d l=%0d/%0d shi=%0d slo=%0d",
                                     period_no, e.pidk, h_c, e.h, l_c, e.l, o_hi, o_lo);
                            chk("h_count", h_c, e.h);
                            chk("l_count", l_c, e.l);
                            chk("sat_hi", o_hi, e.shi);
                            chk("sat_lo", o_lo, e.slo);
                            chk("h_pulses", h_r, (e.h > 0) ? 1 : 0);
                            chk("l_pulses", l_r, (e.l > 0) ? 1 : 0);
                            period_no++;
                        end
                    end
                    in_period = EN;
                    flush_req = 1'b0;
                    h_c = 0; l_c = 0; h_r = 0; l_r = 0;
                    if (EN) begin
                        o_hi = int'(sat_hi);
                        o_lo = int'(sat_lo);
                        en_total++;
                    end
                end
                if (in_period) begin
                    h_c += int'(pwm_h);
                    l_c += int'(pwm_l);
                    if (pwm_h && !ph) h_r++;
                    if (pwm_l && !pl) l_r++;
                end
            end
            ph = pwm_h;
            pl = pwm_l;
        end
    end

    initial begin
        bit ok;
        int en_snap;

        tbl[0]  = '{64000,  246, 242, 0, 0};
        tbl[1]  = '{64000,  246, 242, 0, 0};
        tbl[2]  = '{153600, 496, 0,   1, 0};
        tbl[3]  = '{-256,   0,   492, 0, 1};
        tbl[4]  = '{64000,  246, 242, 0, 0};
        tbl[5]  = '{25600,  96,  392, 0, 0};
        tbl[6]  = '{1280,   1,   487, 0, 0};
        tbl[7]  = '{1024,   0,   488, 0, 0};
        tbl[8]  = '{128000, 496, 0,   0, 0};
        tbl[9]  = '{125952, 488, 0,   0, 0};
        tbl[10] = '{64255,  246, 242, 0, 0};
        tbl[11] = '{-1,     0,   492, 0, 1};
        tbl[12] = '{128256, 496, 0,   1, 0};

        rst  = 1'b1;
        go   = 1'b0;
        pidk = '0;
        repeat (3) @(negedge clk);
        chk("rst_en", int'(EN), 0);
        chk("rst_pwm_h", int'(pwm_h), 0);
        chk("rst_pwm_l", int'(pwm_l), 0);
        chk("rst_sat_hi", int'(sat_hi), 0);
        chk("rst_sat_lo", int'(sat_lo), 0);
        rst = 1'b0;
        @(negedge clk);

        // go pulse that never spans a rising edge must be ignored
        @(posedge clk);
        #1 go = 1'b1;
        #2 go = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_glitch_en", en_seen, 0);
        chk("idle_glitch_pwm_l", int'(pwm_l), 0);

        pidk = 19'(tbl[0].pidk);
        sb_q.push_back(tbl[0]);
        mon_en = 1'b1;
        go = 1'b1;
        for (int i = 1; i < NV; i++) begin
            wait_en(ok);
            repeat (99) @(posedge clk);
            #1;
            pidk = 19'(tbl[i].pidk);
            sb_q.push_back(tbl[i]);
        end
        wait_en(ok);
        repeat (199) @(posedge clk);
        #1 go = 1'b0;
        repeat (320) @(posedge clk);
        #1 flush_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("en_total", en_total, NV);
        en_snap = en_seen;
        repeat (600) @(negedge clk);
        chk("idle_no_en", en_seen - en_snap, 0);
        chk("idle_pwm_h", int'(pwm_h), 0);
        chk("idle_pwm_l", int'(pwm_l), 0);
        mon_en = 1'b0;

        // reset in the middle of a high pulse
        pidk = 19'sd153600;
        go = 1'b1;
        wait_en(ok);
        repeat (299) @(posedge clk);
        #1;
        chk("pre_rst_pwm_h", int'(pwm_h), 1);
        chk("pre_rst_sat_hi", int'(sat_hi), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_pwm_h", int'(pwm_h), 0);
        chk("async_rst_pwm_l", int'(pwm_l), 0);
        chk("async_rst_en", int'(EN), 0);
        chk("async_rst_sat_hi", int'(sat_hi), 0);
        chk("async_rst_sat_lo", int'(sat_lo), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_c1_en", int'(EN), 0);
        chk("restart_c1_sat_hi", int'(sat_hi), 1);
        @(negedge clk);
        chk("restart_c2_en", int'(EN), 1);
        chk("restart_c2_pwm_h", int'(pwm_h), 0);
        @(negedge clk);
        chk("restart_c3_en", int'(EN), 0);
        go = 1'b0;
        repeat (520) @(negedge clk);
        chk("final_pwm_h", int'(pwm_h), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
